// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control sequencer for the processing unit.
// Walks FETCH -> DECODE -> EXECUTE -> (MEMWAIT) -> WRITEBACK and issues the
// registered datapath controls, memory strobes and PC update for each step.
module cpu_control_fsm (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clkEn_i,
    input  logic       inst_ack_i,
    input  logic [3:0] op_i,
    input  logic [2:0] func_i,
    input  logic       carry_i,
    input  logic       zero_i,
    input  logic       data_ack_i,
    output logic       inst_stb_o,
    output logic       ir_ld_o,
    output logic [1:0] RegMux_c_o,
    output logic       RegWrt_c_o,
    output logic       op2_c_o,
    output logic [3:0] ALUOp_c_o,
    output logic       data_stb_o,
    output logic       data_we_o,
    output logic       port_we_o,
    output logic       pc_inc_o,
    output logic       pc_load_o,
    output logic       illegal_o,
    output logic       bus_err_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        FETCH     = 3'b000,
        DECODE    = 3'b001,
        EXECUTE   = 3'b010,
        MEMWAIT   = 3'b011,
        WRITEBACK = 3'b100
    } state_t;

    // Instruction class remembered from DECODE to steer EXECUTE/WRITEBACK.
    typedef enum logic [2:0] {
        CL_NOP   = 3'd0,
        CL_ALU   = 3'd1,
        CL_LOAD  = 3'd2,
        CL_STORE = 3'd3,
        CL_PIN   = 3'd4,
        CL_POUT  = 3'd5,
        CL_JMP   = 3'd6,
        CL_BR    = 3'd7
    } class_t;

    // Branch is taken when the selected flag differs from the polarity bit.
    function automatic logic branch_taken(input logic [2:0] func,
                                          input logic       carry,
                                          input logic       zero);
        return (func[0] ? carry : zero) ^ func[1];
    endfunction

    state_t     state_r;
    class_t     class_r;
    logic [3:0] wait_cnt_r;
    logic       inst_stb_r;
    logic       ir_ld_r;
    logic [1:0] reg_mux_r;
    logic       reg_wrt_r;
    logic       op2_r;
    logic [3:0] alu_op_r;
    logic       data_stb_r;
    logic       data_we_r;
    logic       port_we_r;
    logic       pc_inc_r;
    logic       pc_load_r;
    logic       illegal_r;
    logic       bus_err_r;

    // Sequencer: state, wait counter and every registered control output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= FETCH;
            class_r    <= CL_NOP;
            wait_cnt_r <= 4'd0;
            inst_stb_r <= 1'b0;
            ir_ld_r    <= 1'b0;
            reg_mux_r  <= 2'b00;
            reg_wrt_r  <= 1'b0;
            op2_r      <= 1'b0;
            alu_op_r   <= 4'd0;
            data_stb_r <= 1'b0;
            data_we_r  <= 1'b0;
            port_we_r  <= 1'b0;
            pc_inc_r   <= 1'b0;
            pc_load_r  <= 1'b0;
            illegal_r  <= 1'b0;
            bus_err_r  <= 1'b0;
        end else if (clkEn_i) begin
            // single-cycle pulses fall back to zero unless re-asserted below
            ir_ld_r   <= 1'b0;
            illegal_r <= 1'b0;
            port_we_r <= 1'b0;
            bus_err_r <= 1'b0;
            case (state_r)
                FETCH: begin
                    if (inst_ack_i) begin
                        inst_stb_r <= 1'b0;
                        ir_ld_r    <= 1'b1;
                        state_r    <= DECODE;
                    end else begin
                        inst_stb_r <= 1'b1;
                    end
                end
                DECODE: begin
                    alu_op_r  <= 4'd0;
                    op2_r     <= 1'b0;
                    reg_mux_r <= 2'b00;
                    casez (op_i)
                        4'b0???: begin
                            class_r  <= CL_ALU;
                            alu_op_r <= {1'b0, op_i[2:0]};
                        end
                        4'b1110: begin
                            class_r  <= CL_ALU;
                            alu_op_r <= {1'b0, func_i};
                            op2_r    <= 1'b1;
                        end
                        4'b1100: begin
                            class_r   <= CL_LOAD;
                            reg_mux_r <= 2'b01;
                        end
                        4'b1101: class_r <= CL_STORE;
                        4'b1010: begin
                            class_r   <= CL_PIN;
                            reg_mux_r <= 2'b10;
                        end
                        4'b1011: class_r <= CL_POUT;
                        4'b1000: class_r <= CL_JMP;
                        4'b1001: class_r <= CL_BR;
                        default: begin
                            class_r   <= CL_NOP;
                            illegal_r <= 1'b1;
                        end
                    endcase
                    state_r <= EXECUTE;
                end
                EXECUTE: begin
                    case (class_r)
                        CL_LOAD, CL_STORE: begin
                            data_stb_r <= 1'b1;
                            data_we_r  <= (class_r == CL_STORE);
                            wait_cnt_r <= 4'd0;
                            state_r    <= MEMWAIT;
                        end
                        default: begin
                            reg_wrt_r <= (class_r == CL_ALU) || (class_r == CL_PIN);
                            port_we_r <= (class_r == CL_POUT);
                            if ((class_r == CL_JMP) ||
                                ((class_r == CL_BR) && branch_taken(func_i, carry_i, zero_i))) begin
                                pc_load_r <= 1'b1;
                            end else begin
                                pc_inc_r <= 1'b1;
                            end
                            state_r <= WRITEBACK;
                        end
                    endcase
                end
                MEMWAIT: begin
                    if (data_ack_i) begin
                        data_stb_r <= 1'b0;
                        data_we_r  <= 1'b0;
                        reg_wrt_r  <= (class_r == CL_LOAD);
                        pc_inc_r   <= 1'b1;
                        state_r    <= WRITEBACK;
                    end else if (wait_cnt_r == 4'd14) begin
                        // fifteenth unanswered cycle: give up, no register write
                        wait_cnt_r <= 4'd15;
                        bus_err_r  <= 1'b1;
                        data_stb_r <= 1'b0;
                        data_we_r  <= 1'b0;
                        reg_wrt_r  <= 1'b0;
                        pc_inc_r   <= 1'b1;
                        state_r    <= WRITEBACK;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                WRITEBACK: begin
                    reg_wrt_r <= 1'b0;
                    pc_inc_r  <= 1'b0;
                    pc_load_r <= 1'b0;
                    state_r   <= FETCH;
                end
                default: begin
                    inst_stb_r <= 1'b0;
                    data_stb_r <= 1'b0;
                    data_we_r  <= 1'b0;
                    reg_wrt_r  <= 1'b0;
                    pc_inc_r   <= 1'b0;
                    pc_load_r  <= 1'b0;
                    state_r    <= FETCH;
                end
            endcase
        end
    end

    assign inst_stb_o = inst_stb_r;
    assign ir_ld_o    = ir_ld_r;
    assign RegMux_c_o = reg_mux_r;
    assign RegWrt_c_o = reg_wrt_r;
    assign op2_c_o    = op2_r;
    assign ALUOp_c_o  = alu_op_r;
    assign data_stb_o = data_stb_r;
    assign data_we_o  = data_we_r;
    assign port_we_o  = port_we_r;
    assign pc_inc_o   = pc_inc_r;
    assign pc_load_o  = pc_load_r;
    assign illegal_o  = illegal_r;
    assign bus_err_o  = bus_err_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed self-checking bench for cpu_control_fsm.
module tb_cpu_control_fsm;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       clkEn_i = 1'b1;
    logic       inst_ack_i = 1'b0;
    logic [3:0] op_i = 4'd0;
    logic [2:0] func_i = 3'd0;
    logic       carry_i = 1'b0;
    logic       zero_i = 1'b0;
    logic       data_ack_i = 1'b0;
    logic       inst_stb_o, ir_ld_o, RegWrt_c_o, op2_c_o, data_stb_o, data_we_o;
    logic       port_we_o, pc_inc_o, pc_load_o, illegal_o, bus_err_o;
    logic [1:0] RegMux_c_o;
    logic [3:0] ALUOp_c_o;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;

    cpu_control_fsm dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clkEn_i(clkEn_i), .inst_ack_i(inst_ack_i),
        .op_i(op_i), .func_i(func_i), .carry_i(carry_i), .zero_i(zero_i),
        .data_ack_i(data_ack_i), .inst_stb_o(inst_stb_o), .ir_ld_o(ir_ld_o),
        .RegMux_c_o(RegMux_c_o), .RegWrt_c_o(RegWrt_c_o), .op2_c_o(op2_c_o),
        .ALUOp_c_o(ALUOp_c_o), .data_stb_o(data_stb_o), .data_we_o(data_we_o),
        .port_we_o(port_we_o), .pc_inc_o(pc_inc_o), .pc_load_o(pc_load_o),
        .illegal_o(illegal_o), .bus_err_o(bus_err_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All outputs packed: stb,ir_ld,mux[2],wrt,op2,alu[4],dstb,dwe,pwe,inc,load,ill,berr,state[3]
    function automatic logic [19:0] outs();
        return {inst_stb_o, ir_ld_o, RegMux_c_o, RegWrt_c_o, op2_c_o, ALUOp_c_o,
                data_stb_o, data_we_o, port_we_o, pc_inc_o, pc_load_o,
                illegal_o, bus_err_o, state_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present an instruction with immediate ack and move into DECODE.
    task automatic issue(input logic [3:0] op, input logic [2:0] func);
        op_i = op;
        func_i = func;
        inst_ack_i = 1'b1;
        step();
        inst_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) step();
        checks++;
        if (outs() !== 20'h00000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", outs(), 20'h00000);
        end
        #2 rst_ni = 1'b1;
        clkEn_i = 1'b0;
        step();
        checks++;
        if (outs() !== 20'h00000) begin
            failures++;
            $display("FAIL reset_disabled_hold got=%h exp=%h", outs(), 20'h00000);
        end
        clkEn_i = 1'b1;
        step();
        checks++;
        if (outs() !== 20'h80000) begin
            failures++;
            $display("FAIL first_inst_stb got=%h exp=%h", outs(), 20'h80000);
        end
    endtask

    task automatic test_alu_reg();
        issue(4'b1110, 3'b010);
        checks++;
        if (state_o !== 3'b001 || ir_ld_o !== 1'b1 || inst_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL sub_decode state=%b ir_ld=%b stb=%b exp 001/1/0", state_o, ir_ld_o, inst_stb_o);
        end
        step();
        checks++;
        if (state_o !== 3'b010 || ALUOp_c_o !== 4'b0010 || op2_c_o !== 1'b1 ||
            RegMux_c_o !== 2'b00 || RegWrt_c_o !== 1'b0 || ir_ld_o !== 1'b0) begin
            failures++;
            $display("FAIL sub_execute state=%b alu=%b op2=%b mux=%b wrt=%b exp 010/0010/1/00/0",
                     state_o, ALUOp_c_o, op2_c_o, RegMux_c_o, RegWrt_c_o);
        end
        step();
        checks++;
        if (state_o !== 3'b100 || RegWrt_c_o !== 1'b1 || pc_inc_o !== 1'b1 || pc_load_o !== 1'b0) begin
            failures++;
            $display("FAIL sub_writeback state=%b wrt=%b inc=%b load=%b exp 100/1/1/0",
                     state_o, RegWrt_c_o, pc_inc_o, pc_load_o);
        end
        step();
        checks++;
        if (state_o !== 3'b000 || RegWrt_c_o !== 1'b0 || pc_inc_o !== 1'b0 || inst_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL sub_refetch state=%b wrt=%b inc=%b stb=%b exp 000/0/0/0",
                     state_o, RegWrt_c_o, pc_inc_o, inst_stb_o);
        end
    endtask

    task automatic test_alu_imm();
        int cyc;
        data_ack_i = 1'b1;
        issue(4'b0001, 3'b111);
        cyc = 1;
        step(); cyc++;
        checks++;
        if (ALUOp_c_o !== 4'b0001 || op2_c_o !== 1'b0 || RegMux_c_o !== 2'b00) begin
            failures++;
            $display("FAIL addci_decode alu=%b op2=%b mux=%b exp 0001/0/00", ALUOp_c_o, op2_c_o, RegMux_c_o);
        end
        step(); cyc++;
        checks++;
        if (state_o !== 3'b100 || RegWrt_c_o !== 1'b1 || data_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL addci_writeback state=%b wrt=%b dstb=%b exp 100/1/0", state_o, RegWrt_c_o, data_stb_o);
        end
        step(); cyc++;
        data_ack_i = 1'b0;
        checks++;
        if (state_o !== 3'b000 || cyc != 4) begin
            failures++;
            $display("FAIL addci_latency state=%b cycles=%0d exp 000/4", state_o, cyc);
        end
    endtask

    task automatic test_load_delayed();
        int cyc;
        int stb_cnt;
        stb_cnt = 0;
        issue(4'b1100, 3'b000);
        cyc = 1;
        step(); cyc++;
        checks++;
        if (RegMux_c_o !== 2'b01 || state_o !== 3'b010) begin
            failures++;
            $display("FAIL load_decode mux=%b state=%b exp 01/010", RegMux_c_o, state_o);
        end
        for (int i = 0; i < 4; i++) begin
            step(); cyc++;
            if (data_stb_o === 1'b1 && state_o === 3'b011) stb_cnt++;
        end
        data_ack_i = 1'b1;
        step(); cyc++;
        data_ack_i = 1'b0;
        checks++;
        if (state_o !== 3'b100 || data_stb_o !== 1'b0 || RegWrt_c_o !== 1'b1 ||
            RegMux_c_o !== 2'b01 || pc_inc_o !== 1'b1) begin
            failures++;
            $display("FAIL load_writeback state=%b dstb=%b wrt=%b mux=%b inc=%b exp 100/0/1/01/1",
                     state_o, data_stb_o, RegWrt_c_o, RegMux_c_o, pc_inc_o);
        end
        step(); cyc++;
        checks++;
        if (state_o !== 3'b000 || cyc != 8 || stb_cnt != 4) begin
            failures++;
            $display("FAIL load_latency state=%b cycles=%0d stb_cycles=%0d exp 000/8/4", state_o, cyc, stb_cnt);
        end
    endtask

    task automatic test_store_timeout();
        int mw;
        issue(4'b1101, 3'b000);
        step();
        step();
        checks++;
        if (state_o !== 3'b011 || data_stb_o !== 1'b1 || data_we_o !== 1'b1) begin
            failures++;
            $display("FAIL store_memwait state=%b dstb=%b dwe=%b exp 011/1/1", state_o, data_stb_o, data_we_o);
        end
        mw = 1;
        for (int i = 0; i < 40 && state_o === 3'b011; i++) begin
            step();
            if (state_o === 3'b011) mw++;
        end
        checks++;
        if (mw != 15 || state_o !== 3'b100 || bus_err_o !== 1'b1 || data_we_o !== 1'b0 ||
            data_stb_o !== 1'b0 || RegWrt_c_o !== 1'b0 || pc_inc_o !== 1'b1) begin
            failures++;
            $display("FAIL store_timeout waits=%0d state=%b berr=%b dwe=%b dstb=%b wrt=%b inc=%b exp 15/100/1/0/0/0/1",
                     mw, state_o, bus_err_o, data_we_o, data_stb_o, RegWrt_c_o, pc_inc_o);
        end
        step();
        checks++;
        if (state_o !== 3'b000 || bus_err_o !== 1'b0) begin
            failures++;
            $display("FAIL store_berr_pulse state=%b berr=%b exp 000/0", state_o, bus_err_o);
        end
    endtask

    task automatic test_branch();
        logic [2:0] funcs [4]  = '{3'b001, 3'b001, 3'b010, 3'b000};
        logic       carrys [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       zeros [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_ld [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            carry_i = carrys[i];
            zero_i = zeros[i];
            issue(4'b1001, funcs[i]);
            step();
            step();
            checks++;
            if (state_o !== 3'b100 || pc_load_o !== exp_ld[i] || pc_inc_o !== ~exp_ld[i] || RegWrt_c_o !== 1'b0) begin
                failures++;
                $display("FAIL branch_%0d load=%b inc=%b wrt=%b exp load=%b inc=%b wrt=0",
                         i, pc_load_o, pc_inc_o, RegWrt_c_o, exp_ld[i], ~exp_ld[i]);
            end
            step();
        end
        carry_i = 1'b0;
        zero_i = 1'b0;
        issue(4'b1000, 3'b000);
        step();
        step();
        checks++;
        if (pc_load_o !== 1'b1 || pc_inc_o !== 1'b0) begin
            failures++;
            $display("FAIL jump load=%b inc=%b exp 1/0", pc_load_o, pc_inc_o);
        end
        step();
    endtask

    task automatic test_ports();
        issue(4'b1010, 3'b000);
        step();
        step();
        checks++;
        if (RegMux_c_o !== 2'b10 || RegWrt_c_o !== 1'b1 || port_we_o !== 1'b0) begin
            failures++;
            $display("FAIL port_in mux=%b wrt=%b pwe=%b exp 10/1/0", RegMux_c_o, RegWrt_c_o, port_we_o);
        end
        step();
        issue(4'b1011, 3'b000);
        step();
        step();
        checks++;
        if (port_we_o !== 1'b1 || RegWrt_c_o !== 1'b0 || pc_inc_o !== 1'b1) begin
            failures++;
            $display("FAIL port_out pwe=%b wrt=%b inc=%b exp 1/0/1", port_we_o, RegWrt_c_o, pc_inc_o);
        end
        step();
        checks++;
        if (port_we_o !== 1'b0 || state_o !== 3'b000) begin
            failures++;
            $display("FAIL port_out_pulse pwe=%b state=%b exp 0/000", port_we_o, state_o);
        end
    endtask

    task automatic test_illegal_freeze();
        issue(4'b1111, 3'b000);
        step();
        clkEn_i = 1'b0;
        inst_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs() !== 20'b0_0_00_0_0_0000_0_0_0_0_0_1_0_010) begin
                failures++;
                $display("FAIL freeze_%0d got=%b exp=%b", i, outs(), 20'b0_0_00_0_0_0000_0_0_0_0_0_1_0_010);
            end
        end
        inst_ack_i = 1'b0;
        clkEn_i = 1'b1;
        step();
        checks++;
        if (outs() !== 20'b0_0_00_0_0_0000_0_0_0_1_0_0_0_100) begin
            failures++;
            $display("FAIL illegal_nop got=%b exp=%b", outs(), 20'b0_0_00_0_0_0000_0_0_0_1_0_0_0_100);
        end
        step();
    endtask

    task automatic test_reset_midway();
        issue(4'b1100, 3'b000);
        step();
        step();
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (outs() !== 20'h00000) begin
            failures++;
            $display("FAIL reset_immediate got=%h exp=%h", outs(), 20'h00000);
        end
        data_ack_i = 1'b1;
        step();
        data_ack_i = 1'b0;
        #2 rst_ni = 1'b1;
        step();
        checks++;
        if (outs() !== 20'h80000) begin
            failures++;
            $display("FAIL reset_restart got=%h exp=%h", outs(), 20'h80000);
        end
    endtask

    initial begin
        test_reset();
        test_alu_reg();
        test_alu_imm();
        test_load_delayed();
        test_store_timeout();
        test_branch();
        test_ports();
        test_illegal_freeze();
        test_reset_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 The block SHALL have one clock and reset as follows: clk_i  in  1  rising-edge clock; rst_ni  in  1  asynchronous, active-low reset.
REQ-002 The block SHALL have these inputs, in this order:
- clkEn_i  in  1  clock enable; all state advances only when high.
- inst_ack_i  in  1  instruction-memory acknowledge.
- op_i  in  4  instruction bits [17:14] from the processing unit.
- func_i  in  3  instruction bits [2:0].
- carry_i  in  1  registered ALU carry flag.
- zero_i  in  1  registered ALU zero flag.
- data_ack_i  in  1  data-memory acknowledge.
REQ-003 The block SHALL have these outputs:
- inst_stb_o  out  1  instruction fetch request.
- ir_ld_o  out  1  instruction-register load strobe.
- RegMux_c_o  out  2  writeback source: 00 ALU, 01 data memory, 10 port.
- RegWrt_c_o  out  1  register-bank write enable.
- op2_c_o  out  1  ALU operand 2 select: 0 immediate, 1 rs2.
- ALUOp_c_o  out  4  ALU operation.
- data_stb_o  out  1  data-memory request.
- data_we_o  out  1  data-memory write qualifier.
- port_we_o  out  1  output-port write strobe.
- pc_inc_o  out  1  PC increment.
- pc_load_o  out  1  PC load from addr/disp.
- illegal_o  out  1  illegal opcode pulse.
- bus_err_o  out  1  data-memory timeout pulse.
- state_o  out  3  current state.

Function
REQ-004 The state encoding SHALL be FETCH=000, DECODE=001, EXECUTE=010, MEMWAIT=011, WRITEBACK=100; all other codes SHALL return to FETCH on the next enabled edge.
REQ-005 When clkEn_i=0, the state, all registered outputs and the wait counter SHALL hold their values.
REQ-006 FETCH: inst_stb_o is registered, is set on the first enabled edge in FETCH, and is held until inst_ack_i is sampled high. On that edge, ir_ld_o SHALL pulse for 1 cycle, inst_stb_o SHALL clear, and the next state SHALL be DECODE.
REQ-007 DECODE SHALL always advance to EXECUTE after 1 cycle. It SHALL register the decoded controls as follows:
- op_i=0xxx: ALU immediate; ALUOp_c_o={1'b0,op_i[2:0]}, op2_c_o=0, RegMux_c_o=00.
- op_i=1110: ALU register; ALUOp_c_o={1'b0,func_i}, op2_c_o=1, RegMux_c_o=00.
- op_i=1100: load, RegMux_c_o=01.
- op_i=1101: store.
- op_i=1010: port input, RegMux_c_o=10.
- op_i=1011: port output.
- op_i=1000: jump.
- op_i=1001: conditional branch.
- op_i=1111: illegal; illegal_o SHALL pulse for 1 cycle and the instruction SHALL execute as a NOP.
REQ-008 EXECUTE SHALL proceed as follows:
- Load and store: data_stb_o=1 (data_we_o=1 for store only); next state MEMWAIT.
- Port output: port_we_o SHALL pulse for 1 cycle.
- All other instructions: next state WRITEBACK.
REQ-009 MEMWAIT SHALL hold data_stb_o/data_we_o until data_ack_i is sampled high, then clear them and go to WRITEBACK. A 4-bit wait counter SHALL be cleared on entry; if the count reaches 15 without an ack, bus_err_o SHALL pulse for 1 cycle, the strobes SHALL drop, and WRITEBACK SHALL suppress RegWrt_c_o.
REQ-010 WRITEBACK SHALL last 1 cycle and then go to FETCH, with these outputs:
- RegWrt_c_o=1 for ALU, load (without timeout) and port input.
- pc_load_o=1 for a jump or a taken branch.
- pc_inc_o=1 otherwise; pc_inc_o and pc_load_o SHALL never be high together.
REQ-011 The branch condition SHALL be sampled in EXECUTE: cond = func_i[0] ? carry_i : zero_i; taken = cond XOR func_i[1].
REQ-012 Latency with immediate ack SHALL be: ALU/port/jump/branch = 4 cycles FETCH-to-FETCH; load/store = 5 cycles plus N cycles of data-ack wait.
REQ-013 If inst_ack_i is high outside FETCH or data_ack_i is high outside MEMWAIT, it SHALL be ignored.

Reset
REQ-014 While rst_ni=0, the state SHALL be FETCH (state_o=000), every other output SHALL be 0, and the wait counter SHALL be 0.
REQ-015 Reset asserted mid-instruction SHALL abort it immediately, with no RegWrt_c_o, pc_inc_o or data_stb_o pulse afterwards. The first inst_stb_o SHALL appear on the first enabled edge after rst_ni rises.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- op_i=1110, func_i=010 (sub), ack on the first cycle: states 000→001→010→100→000. ALUOp_c_o=0010, op2_c_o=1, and RegWrt_c_o=1 only in WRITEBACK together with pc_inc_o.
- op_i=0001 (addci): ALUOp_c_o=0001, op2_c_o=0, RegMux_c_o=00, RegWrt_c_o in WRITEBACK.
- Load with data_ack_i delayed 3 cycles: data_stb_o held for 4 cycles, RegMux_c_o=01, RegWrt_c_o=1; 8 cycles FETCH-to-FETCH.
- Store with no data_ack_i: bus_err_o pulses after 15 wait cycles, data_we_o drops, RegWrt_c_o stays 0, pc_inc_o=1.
- Branch op_i=1001, func_i=001 with carry_i=1: pc_load_o=1, pc_inc_o=0. The same branch with carry_i=0: pc_inc_o=1.
- clkEn_i low for 3 cycles in EXECUTE: state_o and all outputs frozen. rst_ni pulsed low in MEMWAIT: all outputs 0 immediately and state_o=000.
